rijndael_shift_rows_pipe: RTL and testbench

Parametrised ShiftRows / InvShiftRows stage for the IP-stream AES datapath. It supports Rijndael block widths of 128, 192 and 256 bits (Nb = 4/6/8 columns) and selects encrypt or decrypt per transaction. It has valid/ready handshakes on both sides, a DEPTH-entry output buffer that absorbs downstream stalls, and a sideband tag carried alongside each block. It sits between SubBytes and MixColumns in the round pipeline and replaces the fixed 128-bit, ready/done-pulsed row-shift stage.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/rijndael_row_perm.sv | 27 ++
 rtl/rijndael_shift_rows_pipe.sv | 102 ++++++++++
 tb/tb_rijndael_shift_rows_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared helpers for the AES/Rijndael round stages: row offsets, byte
// addressing inside the column-major state, and the legal-NB check.
package aes_pkg;

  localparam int ROWS = 4;

  // Bit n set means NB = n is a supported Rijndael block width (4, 6, 8).
  localparam logic [8:0] NB_LEGAL_MASK = 9'b1_0101_0000;

  typedef enum logic {
    MODE_DEC = 1'b0,
    MODE_ENC = 1'b1
  } shift_mode_e;

  function automatic bit nb_is_legal(input int nb);
    if (nb < 0 || nb > 8) return 1'b0;
    return NB_LEGAL_MASK[nb];
  endfunction

  // Rows 2 and 3 shift further for the 256-bit block.
  function automatic int row_off(input int nb, input int r);
    case (r)
      0:       return 0;
      1:       return 1;
      2:       return (nb == 8) ? 3 : 2;
      default: return (nb == 8) ? 4 : 3;
    endcase
  endfunction

  // Byte k of the state sits at row k mod 4, column k div 4.
  function automatic int byte_idx(input int r, input int c);
    return r + ROWS * c;
  endfunction

endpackage

// File: rtl/rijndael_row_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for NB columns.
// Every output byte is a fixed two-way choice between its encrypt source
// and its decrypt source, so the whole stage is just a row of 2:1 muxes.
module rijndael_row_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] data,
  input  logic             encrypt,
  output logic [32*NB-1:0] perm
);

  localparam int W = 32 * NB;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int DST     = byte_idx(r, c);
      localparam int SRC_ENC = byte_idx(r, (c + row_off(NB, r)) % NB);
      localparam int SRC_DEC = byte_idx(r, (c + NB - row_off(NB, r)) % NB);

      assign perm[W-1-8*DST -: 8] = (encrypt == MODE_ENC) ? data[W-1-8*SRC_ENC -: 8]
                                                          : data[W-1-8*SRC_DEC -: 8];
    end
  end

endmodule

// File: rtl/rijndael_shift_rows_pipe.sv
// ShiftRows / InvShiftRows stage with valid/ready on both sides and a
// DEPTH-entry circular output buffer. Blocks are permuted on the way in,
// so the buffer only ever holds finished results plus their tags.
module rijndael_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int DEPTH = 2,
  parameter int TAG_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [32*NB-1:0]           in_data,
  input  logic                       in_encrypt,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [32*NB-1:0]           out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int W  = 32 * NB;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  if (!nb_is_legal(NB)) begin : g_bad_nb
    $error("rijndael_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rijndael_shift_rows_pipe: DEPTH must be a power of two >= 2");
  end

  logic [W-1:0]     perm_data;
  logic [W-1:0]     buf_data_q [DEPTH];
  logic [TAG_W-1:0] buf_tag_q  [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop;

  rijndael_row_perm #(.NB(NB)) u_perm (
    .data    (in_data),
    .encrypt (in_encrypt),
    .perm    (perm_data)
  );

  // Next pointer/occupancy state; ready and valid are precomputed so the
  // ports come straight from flops and out_ready never reaches in_ready.
  always_comb begin
    push     = in_valid && in_ready_q;
    pop      = out_valid_q && out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    in_ready_d  = (level_d < LW'(DEPTH));
    out_valid_d = (level_d != '0);
  end

  // Control registers; reset empties the buffer logically without touching storage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Buffer storage: write the permuted block at the tail on accept.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      buf_data_q[wr_ptr_q] <= perm_data;
      buf_tag_q[wr_ptr_q]  <= in_tag;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign out_data  = buf_data_q[rd_ptr_q];
  assign out_tag   = buf_tag_q[rd_ptr_q];

endmodule

// File: tb/tb_rijndael_shift_rows_pipe.sv
// Scoreboard bench for rijndael_shift_rows_pipe: one NB=4 and one NB=8
// instance, directed vectors with hand-computed results, a queue per
// instance filled on accept and drained by a monitor on every output beat.
module tb_rijndael_shift_rows_pipe;

  typedef struct {
    logic [255:0] data;
    logic [7:0]   tag;
  } exp_t;

  localparam logic [255:0] A16   = 256'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [255:0] B16   = 256'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [255:0] SEQ16 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] ENC16 = 256'h00050a0f04090e03080d02070c01060b;
  localparam logic [255:0] DEC16 = 256'h000d0a0704010e0b0805020f0c090603;
  localparam logic [255:0] SEQ32 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] ENC32 =
    256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;
  localparam logic [255:0] DEC32 =
    256'h001d1613_04011a17_08051e1b_0c09021f_100d0603_14110a07_18150e0b_1c19120f;

  logic clk = 1'b0;
  logic reset_n;

  logic         in_valid4, in_ready4, in_encrypt4, out_valid4, out_ready4;
  logic [127:0] in_data4, out_data4;
  logic [7:0]   in_tag4, out_tag4;
  logic [1:0]   level4;

  logic         in_valid8, in_ready8, in_encrypt8, out_valid8, out_ready8;
  logic [255:0] in_data8, out_data8;
  logic [7:0]   in_tag8, out_tag8;
  logic [1:0]   level8;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rijndael_shift_rows_pipe #(.NB(4), .DEPTH(2), .TAG_W(8)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .in_encrypt(in_encrypt4), .in_tag(in_tag4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_tag(out_tag4), .level(level4)
  );

  rijndael_shift_rows_pipe #(.NB(8), .DEPTH(2), .TAG_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .in_encrypt(in_encrypt8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_tag(out_tag8), .level(level8)
  );

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one block, wait (bounded) for acceptance, then queue its expected result.
  task automatic applyStimulus(input bit sel8, input logic [255:0] data, input bit enc,
                               input logic [7:0] tag, input logic [255:0] exp);
    exp_t e;
    int   waited;
    bit   rdy;
    if (sel8) begin
      in_valid8 = 1'b1; in_data8 = data; in_encrypt8 = enc; in_tag8 = tag;
    end else begin
      in_valid4 = 1'b1; in_data4 = data[127:0]; in_encrypt4 = enc; in_tag4 = tag;
    end
    waited = 0;
    @(negedge clk);
    rdy = sel8 ? in_ready8 : in_ready4;
    while (!rdy && waited < 64) begin
      @(negedge clk);
      rdy = sel8 ? in_ready8 : in_ready4;
      waited++;
    end
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: tag %0h not accepted, got ready 0 expected 1", tag);
    end else begin
      @(posedge clk);
      e.data = exp;
      e.tag  = tag;
      if (sel8) q8.push_back(e);
      else      q4.push_back(e);
      #1;
    end
  endtask

  task automatic idle();
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
  endtask

  task automatic waitDrain();
    int w = 0;
    while ((q4.size() != 0 || q8.size() != 0) && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (q4.size() != 0 || q8.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d/%0d pending expected 0/0", q4.size(), q8.size());
    end
  endtask

  // Monitor: every consumed output beat must match the head of its scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid4 === 1'b1 && out_ready4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL nb4_unexpected: got tag %0h expected no output", out_tag4);
      end else begin
        e4 = q4.pop_front();
        checkOutput("nb4_data", {128'b0, out_data4}, e4.data);
        checkFlag("nb4_tag", out_tag4, e4.tag);
      end
    end
    if (reset_n === 1'b1 && out_valid8 === 1'b1 && out_ready8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL nb8_unexpected: got tag %0h expected no output", out_tag8);
      end else begin
        e8 = q8.pop_front();
        checkOutput("nb8_data", out_data8, e8.data);
        checkFlag("nb8_tag", out_tag8, e8.tag);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; in_encrypt4 = 1'b0; in_tag4 = '0; out_ready4 = 1'b0;
    in_valid8 = 1'b0; in_data8 = '0; in_encrypt8 = 1'b0; in_tag8 = '0; out_ready8 = 1'b0;

    // Reset state
    @(posedge clk); #1;
    checkFlag("rst_level4", 8'(level4), 8'd0);
    checkFlag("rst_valid4", 8'(out_valid4), 8'd0);
    checkFlag("rst_ready4", 8'(in_ready4), 8'd1);
    checkFlag("rst_level8", 8'(level8), 8'd0);
    checkFlag("rst_valid8", 8'(out_valid8), 8'd0);
    checkFlag("rst_ready8", 8'(in_ready8), 8'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // NB=4 encrypt with one-cycle latency, then decrypt
    out_ready4 = 1'b1;
    applyStimulus(1'b0, A16, 1'b1, 8'h11, B16);
    idle();
    checkFlag("nb4_latency_valid", 8'(out_valid4), 8'd1);
    checkOutput("nb4_latency_data", {128'b0, out_data4}, B16);
    waitDrain();
    applyStimulus(1'b0, B16, 1'b0, 8'h12, A16);
    idle();
    waitDrain();

    // NB=4 mixed modes back to back
    applyStimulus(1'b0, A16, 1'b1, 8'h21, B16);
    applyStimulus(1'b0, B16, 1'b0, 8'h22, A16);
    applyStimulus(1'b0, A16, 1'b1, 8'h23, B16);
    applyStimulus(1'b0, B16, 1'b0, 8'h24, A16);
    applyStimulus(1'b0, SEQ16, 1'b1, 8'h25, ENC16);
    applyStimulus(1'b0, SEQ16, 1'b0, 8'h26, DEC16);
    idle();
    waitDrain();

    // NB=8 encrypt, decrypt round trip, and plain decrypt
    out_ready8 = 1'b1;
    applyStimulus(1'b1, SEQ32, 1'b1, 8'h31, ENC32);
    applyStimulus(1'b1, ENC32, 1'b0, 8'h32, SEQ32);
    applyStimulus(1'b1, SEQ32, 1'b0, 8'h33, DEC32);
    idle();
    waitDrain();

    // Backpressure: third block must wait while the buffer is full
    out_ready4 = 1'b0;
    applyStimulus(1'b0, A16, 1'b1, 8'h01, B16);
    applyStimulus(1'b0, B16, 1'b0, 8'h02, A16);
    in_valid4 = 1'b1; in_data4 = SEQ16[127:0]; in_encrypt4 = 1'b1; in_tag4 = 8'h03;
    @(negedge clk);
    checkFlag("bp_level_full", 8'(level4), 8'd2);
    checkFlag("bp_in_ready_low", 8'(in_ready4), 8'd0);
    checkOutput("bp_head_data", {128'b0, out_data4}, B16);
    checkFlag("bp_head_tag", out_tag4, 8'h01);
    repeat (3) @(negedge clk);
    checkOutput("bp_head_stable", {128'b0, out_data4}, B16);
    checkFlag("bp_still_full", 8'(level4), 8'd2);
    checkFlag("bp_ready_still_low", 8'(in_ready4), 8'd0);
    @(posedge clk); #1;
    out_ready4 = 1'b1;
    applyStimulus(1'b0, SEQ16, 1'b1, 8'h03, ENC16);
    idle();
    waitDrain();

    // Simultaneous push and pop at level 1
    out_ready4 = 1'b0;
    applyStimulus(1'b0, A16, 1'b1, 8'h40, B16);
    checkFlag("pp_level_start", 8'(level4), 8'd1);
    out_ready4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) applyStimulus(1'b0, B16, 1'b0, 8'(8'h41 + i), A16);
      else            applyStimulus(1'b0, A16, 1'b1, 8'(8'h41 + i), B16);
      checkFlag("pp_level_steady", 8'(level4), 8'd1);
    end
    idle();
    waitDrain();

    // Reset mid-stream discards the buffered blocks
    out_ready4 = 1'b0;
    applyStimulus(1'b0, A16, 1'b1, 8'h60, B16);
    applyStimulus(1'b0, SEQ16, 1'b1, 8'h61, ENC16);
    idle();
    checkFlag("mr_level_before", 8'(level4), 8'd2);
    reset_n = 1'b0;
    @(posedge clk); #1;
    q4.delete();
    reset_n = 1'b1;
    checkFlag("mr_valid", 8'(out_valid4), 8'd0);
    checkFlag("mr_level", 8'(level4), 8'd0);
    checkFlag("mr_ready", 8'(in_ready4), 8'd1);
    out_ready4 = 1'b1;
    applyStimulus(1'b0, SEQ16, 1'b0, 8'h62, DEC16);
    idle();
    waitDrain();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
